ingress_port: RTL and testbench
===============================

# ingress_port

Per-port ingress stage of the 4-port switch, one instance per input port, directly upstream of the switch arbiter. It buffers incoming single-beat packets in a FIFO and presents the head packet's request and one-hot destination mask to the arbiter. On grant it pops the head and drives its payload to the crossbar one cycle later, aligned with the arbiter's registered mux selects and output-active flags.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DATA_WIDTH, packet_pkg::DATA_WIDTH: payload width.
- clk  in  1  switch clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source has a packet.
- in_ready  out  1  FIFO can accept this cycle.
- in_data  in  DATA_WIDTH  packet payload.
- in_dst  in  ADDR_WIDTH  one-hot/multicast destination mask, bit i selects output i.
- port_req  out  1  to arbiter port_reqs[n]; head packet pending.
- port_dst  out  ADDR_WIDTH  to arbiter portN_dst; head destination mask.
- grant  in  1  from arbiter grant_bus[n]; combinational, same cycle as port_req.
- out_valid  out  1  granted payload valid on out_data (crossbar side).
- out_data  out  DATA_WIDTH  granted payload.
- fifo_count  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Push: in_valid && in_ready at posedge. Packet with in_dst == 0 is discarded (not stored, in_ready unaffected). Otherwise {in_dst, in_data} is written at wr_ptr, and wr_ptr increments mod DEPTH.
- in_ready = (fifo_count < DEPTH), derived from registered count only. There is no combinational path from grant to in_ready. When full, a same-cycle pop does not free a slot for a same-cycle push.
- port_req = (fifo_count != 0). port_dst = head dst mask when port_req is high, else 0. Both are driven combinationally from registered FIFO state.
- Pop: grant && port_req at posedge. The head is read, rd_ptr increments mod DEPTH, out_data <= head payload, out_valid <= 1.
- out_valid is a one-cycle pulse per grant. out_data holds its last value when out_valid is low.
- grant while port_req is low is ignored: no pop, out_valid stays 0.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Multicast: one pop per granted packet regardless of mask popcount. Replication is the crossbar's job.

## Timing
- Reset (async assert, sync deassert by system): wr_ptr = rd_ptr = 0, fifo_count = 0, out_valid = 0, out_data = 0. Hence port_req = 0, port_dst = 0, in_ready = 1.
- Reset mid-operation: all stored packets are lost. No partial state survives.
- Push-to-request latency is 1 cycle: a packet accepted at edge k raises port_req after edge k.
- Grant-to-data latency is 1 cycle: grant in cycle k gives out_valid/out_data in cycle k+1, the same cycle the arbiter's mux_sel/active for cycle-k grants are valid.
- Back-to-back grants pop one packet per cycle. Sustained throughput is 1 packet/cycle.
- Pointer wrap: DEPTH-1 → 0, with no bubble.

## Configuration
- INGRESS_STATS_EN defined:
  - Adds output ports stat_fwd_cnt [15:0] and stat_drop_cnt [15:0], both reset to 0.
  - stat_fwd_cnt increments on each pop.
  - stat_drop_cnt increments on each zero-mask discard.
  - Both counters saturate at 16'hFFFF.
- INGRESS_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- packet_pkg holds NUM_PORTS, ADDR_WIDTH, DATA_WIDTH and a typedef ingress_entry_t = {dst mask, payload}.
- Sub-module sync_fifo: parameterised DEPTH and width, with push, pop, full, empty and count. It is reused by later output-queue work.
- ingress_port contains the zero-mask filter, the output register, request generation and the optional stats counters.

## Test plan
- Reset, then push data 0xA5 with dst 4'b0100 → port_req = 1 and port_dst = 4'b0100 the next cycle. Hold grant one cycle → out_valid = 1, out_data = 0xA5 the cycle after; port_req = 0.
- Fill DEPTH=4 with no grant → in_ready = 0 and fifo_count = 4. A fifth in_valid is not accepted. Grant once → in_ready returns to 1 the following cycle.
- Push 6 packets interleaved with continuous grant → output order equals input order across pointer wrap, one out_valid pulse per grant.
- Push dst 4'b0000 → not stored, port_req stays 0. With INGRESS_STATS_EN, stat_drop_cnt = 1.
- Assert grant with an empty FIFO → no out_valid, pointers unchanged. Simultaneous push and pop at count = 2 → count stays 2.
- Assert rst_n low with 3 packets queued → fifo_count = 0, out_valid = 0 and port_req = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/packet_pkg.sv
// Shared switch packet definitions: port count, destination-mask width,
// payload width and the ingress FIFO entry layout {dst mask, payload}.
package packet_pkg;

    localparam int unsigned NUM_PORTS  = 4;
    localparam int unsigned ADDR_WIDTH = NUM_PORTS;
    localparam int unsigned DATA_WIDTH = 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] dst;
        logic [DATA_WIDTH-1:0] data;
    } ingress_entry_t;

endpackage

// File: rtl/ingress_port_if.sv
// Ingress port bus bundle: source-side push handshake, arbiter request/grant
// and crossbar-side granted payload.
//   master : source + arbiter + crossbar (drives in_*, grant)
//   slave  : ingress_port (drives in_ready, port_*, out_*)
interface ingress_port_if #(
    parameter int unsigned DATA_WIDTH = packet_pkg::DATA_WIDTH
) ();

    logic                              in_valid;
    logic                              in_ready;
    logic [DATA_WIDTH-1:0]             in_data;
    logic [packet_pkg::ADDR_WIDTH-1:0] in_dst;
    logic                              port_req;
    logic [packet_pkg::ADDR_WIDTH-1:0] port_dst;
    logic                              grant;
    logic                              out_valid;
    logic [DATA_WIDTH-1:0]             out_data;

    modport master (
        output in_valid, in_data, in_dst, grant,
        input  in_ready, port_req, port_dst, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_dst, grant,
        output in_ready, port_req, port_dst, out_valid, out_data
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata (head, read
// combinationally), full, empty, count. Push while full and pop while empty
// are ignored. DEPTH must be a power of two >= 2 so pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for a same-cycle push.
    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer and occupancy state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone defines which entries are live
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ingress_port.sv
// Per-port ingress stage of the 4-port switch. Buffers single-beat packets,
// drops zero-mask packets, presents head request/destination to the arbiter
// and registers the granted payload toward the crossbar one cycle after grant.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : in_valid/in_ready/in_data/in_dst, port_req/port_dst,
//                  grant, out_valid/out_data
//   fifo_count   : current FIFO occupancy
//   stat_fwd_cnt, stat_drop_cnt : saturating counters, present only when
//                  INGRESS_STATS_EN is defined
module ingress_port
    import packet_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = packet_pkg::DATA_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    ingress_port_if.slave              bus,
`ifdef INGRESS_STATS_EN
    output logic [15:0]                stat_fwd_cnt,
    output logic [15:0]                stat_drop_cnt,
`endif
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

    logic [ENTRY_W-1:0]    head;
    logic [ADDR_WIDTH-1:0] head_dst;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  full;
    logic                  empty;
    logic                  accept;
    logic                  zero_mask;
    logic                  push;
    logic                  pop;

    assign accept    = bus.in_valid && !full;
    assign zero_mask = (bus.in_dst == '0);
    assign push      = accept && !zero_mask;
    assign pop       = bus.grant && !empty;

    assign head_dst  = head[ENTRY_W-1 -: ADDR_WIDTH];
    assign head_data = head[DATA_WIDTH-1:0];

    // Request side is combinational from registered FIFO state only
    assign bus.in_ready = !full;
    assign bus.port_req = !empty;
    assign bus.port_dst = empty ? '0 : head_dst;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({bus.in_dst, bus.in_data}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    // Granted payload register, aligned with the arbiter's registered selects
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bus.out_valid <= pop;
            if (pop) bus.out_data <= head_data;
        end
    end

`ifdef INGRESS_STATS_EN
    // Saturating forward/drop counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (pop && (stat_fwd_cnt != 16'hFFFF))
                stat_fwd_cnt <= stat_fwd_cnt + 16'(1);
            if (accept && zero_mask && (stat_drop_cnt != 16'hFFFF))
                stat_drop_cnt <= stat_drop_cnt + 16'(1);
        end
    end
`endif

endmodule

// File: tb/tb_ingress_port.sv
// Scoreboard bench for ingress_port: stimulus updates a queue model of the
// FIFO and pushes expected granted payloads; a monitor checks out_valid and
// out_data one cycle after each grant.
module tb_ingress_port;
    import packet_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [$clog2(DEPTH+1)-1:0] fifo_count;
`ifdef INGRESS_STATS_EN
    logic [15:0] stat_fwd_cnt;
    logic [15:0] stat_drop_cnt;
`endif

    always #5 clk = ~clk;

    ingress_port_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

    ingress_port #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
`ifdef INGRESS_STATS_EN
        .stat_fwd_cnt  (stat_fwd_cnt),
        .stat_drop_cnt (stat_drop_cnt),
`endif
        .fifo_count    (fifo_count)
    );

    ingress_entry_t        model_q[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    int                    m_fwd;
    int                    m_drop;
    int                    n_vec;
    int                    n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        logic [ADDR_WIDTH-1:0] edst;
        edst = (model_q.size() != 0) ? model_q[0].dst : '0;
        chk("port_req",   32'(bus.port_req), 32'(model_q.size() != 0));
        chk("port_dst",   32'(bus.port_dst), 32'(edst));
        chk("in_ready",   32'(bus.in_ready), 32'(model_q.size() < DEPTH));
        chk("fifo_count", 32'(fifo_count),   32'(model_q.size()));
`ifdef INGRESS_STATS_EN
        chk("stat_fwd",   32'(stat_fwd_cnt),  32'(m_fwd));
        chk("stat_drop",  32'(stat_drop_cnt), 32'(m_drop));
`endif
    endtask

    // One clock of stimulus; model applies what the coming edge should do
    task automatic cycle(input logic v, input logic [ADDR_WIDTH-1:0] d,
                         input logic [DATA_WIDTH-1:0] x, input logic g);
        bit             do_pop;
        bit             do_acc;
        ingress_entry_t e;
        @(negedge clk);
        check_state();
        bus.in_valid = v;
        bus.in_dst   = d;
        bus.in_data  = x;
        bus.grant    = g;
        do_pop = g && (model_q.size() != 0);
        do_acc = v && (model_q.size() < DEPTH);
        if (do_pop) begin
            e = model_q.pop_front();
            exp_q.push_back(e.data);
            m_fwd++;
        end
        if (do_acc) begin
            if (d != '0) begin
                e.dst  = d;
                e.data = x;
                model_q.push_back(e);
            end else begin
                m_drop++;
            end
        end
    endtask

    // Monitor: every grant of a non-empty FIFO yields exactly one pulse next cycle
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                if (bus.out_valid) chk("out_data", 32'(bus.out_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic mid_reset();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.grant    = 1'b0;
        check_state();
        chk("pre_reset_count", 32'(fifo_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count",     32'(fifo_count),    32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_port_req",  32'(bus.port_req),  32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        model_q.delete();
        exp_q.delete();
        m_fwd  = 0;
        m_drop = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_err = 0; m_fwd = 0; m_drop = 0;
        bus.in_valid = 1'b0;
        bus.in_dst   = '0;
        bus.in_data  = '0;
        bus.grant    = 1'b0;
        #1;
        chk("reset_port_req",  32'(bus.port_req),  32'd0);
        chk("reset_port_dst",  32'(bus.port_dst),  32'd0);
        chk("reset_in_ready",  32'(bus.in_ready),  32'd1);
        chk("reset_count",     32'(fifo_count),    32'd0);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_data",  32'(bus.out_data),  32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single packet through
        cycle(1'b1, 4'b0100, 8'hA5, 1'b0);
        @(posedge clk); #1;
        chk("first_port_req", 32'(bus.port_req), 32'd1);
        chk("first_port_dst", 32'(bus.port_dst), 32'b0100);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        cycle(1'b0, 4'b0000, 8'h00, 1'b0);
        cycle(1'b0, 4'b0000, 8'h00, 1'b0);

        // Fill to full, fifth push refused, one grant frees a slot
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 4'(1 << (i % 4)), 8'(8'h30 + i), 1'b0);
        @(posedge clk); #1;
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        chk("full_count",    32'(fifo_count),   32'd4);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        cycle(1'b0, 4'b0000, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("refill_in_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 8'h00, 1'b1);

        // Six packets with continuous grant, across pointer wrap
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 4'(1 << (i % 4)), 8'(8'h50 + i), 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 8'h00, 1'b1);

        // Zero-mask discard and grant on empty
        cycle(1'b1, 4'b0000, 8'h77, 1'b0);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);

        // Push + pop at count 2
        cycle(1'b1, 4'b0011, 8'h61, 1'b0);
        cycle(1'b1, 4'b1000, 8'h62, 1'b0);
        cycle(1'b1, 4'b1111, 8'h63, 1'b1);
        @(posedge clk); #1;
        chk("pushpop_count", 32'(fifo_count), 32'd2);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b0000, 8'h00, 1'b1);

        // Asynchronous reset with three packets queued and a pulse on out_valid
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0010, 8'(8'h90 + i), 1'b0);
        cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        mid_reset();

        // Randomized traffic with varying grant pressure
        for (int i = 0; i < 3000; i++) begin
            logic                  v;
            logic [ADDR_WIDTH-1:0] d;
            logic                  g;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 7) == 0) ? '0 : 4'($urandom_range(1, 15));
            if (i < 1000)      g = ($urandom_range(0, 3) == 0);
            else if (i < 2000) g = ($urandom_range(0, 1) == 1);
            else               g = ($urandom_range(0, 7) != 0);
            cycle(v, d, 8'($urandom), g);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'b0000, 8'h00, 1'b1);
        cycle(1'b0, 4'b0000, 8'h00, 1'b0);
        @(posedge clk); #2;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
